// File: rtl/gpr_writeback_pkg.sv
// Shared picomips definitions used by the GPR write-back block: default widths and the buffered load entry.
package picomips_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_AW     = 3;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Occupancy update for the load buffer; push and pop together leave it unchanged.
    function automatic logic [1:0] count_next(input logic [1:0] count,
                                              input logic       push,
                                              input logic       pop);
        return count + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/gpr_writeback_if.sv
// Bundle of the ALU result, load handshake, register-file write port, hazard query and bypass signals.
interface gpr_writeback_if #(
    parameter int N      = 8,
    parameter int R_SIZE = 3
);
    logic              aluValid;
    logic [N-1:0]      aluData;
    logic [R_SIZE-1:0] aluAddr;
    logic              ldValid;
    logic [N-1:0]      ldData;
    logic [R_SIZE-1:0] ldAddr;
    logic              ldReady;
    logic              wrEnable;
    logic [N-1:0]      wrData;
    logic [R_SIZE-1:0] wrAddr;
    logic [R_SIZE-1:0] qAddr;
    logic              qPending;
    logic              bypValid;
    logic [N-1:0]      bypData;

    modport master (
        output aluValid, aluData, aluAddr,
        output ldValid, ldData, ldAddr,
        input  ldReady,
        input  wrEnable, wrData, wrAddr,
        output qAddr,
        input  qPending, bypValid, bypData
    );

    modport slave (
        input  aluValid, aluData, aluAddr,
        input  ldValid, ldData, ldAddr,
        output ldReady,
        output wrEnable, wrData, wrAddr,
        input  qAddr,
        output qPending, bypValid, bypData
    );
endinterface

// File: rtl/gpr_writeback_fifo.sv
// Two-entry registered load buffer (module wb_fifo); exposes every slot and its valid bit so the
// write-back top can search pending destinations.
module wb_fifo
    import picomips_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  entry_t     push_entry,
    output logic       full,
    output logic       empty,
    output logic [1:0] count,
    output entry_t     head,
    output entry_t     entries [FIFO_DEPTH],
    output logic [1:0] valid
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_next(count_q, push_ok, pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A slot is written only when the write pointer selects it; push and pop never hit the same
    // slot in one cycle because that would need the buffer to be both empty and full.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        logic   valid_q;
        entry_t mem_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
            end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
                valid_q <= 1'b1;
            end else if (pop_ok && (rd_ptr_q == 1'(gi))) begin
                valid_q <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_q == 1'(gi))) begin
                mem_q <= push_entry;
            end
        end

        assign entries[gi] = mem_q;
        assign valid[gi]   = valid_q;
    end

    assign head = rd_ptr_q ? entries[1] : entries[0];

endmodule

// File: rtl/gpr_writeback.sv
// Write side of the GPR file: ALU results win over buffered loads, outputs are registered.
// Build macro WB_BYPASS_EN adds forwarding of the write being committed this cycle.
module gpr_writeback
    import picomips_pkg::*;
#(
    parameter int N      = DATA_W,
    parameter int R_SIZE = REG_AW
) (
    input  logic             clk,
    input  logic             reset,
    gpr_writeback_if.slave   bus
);

    typedef struct packed {
        logic [R_SIZE-1:0] addr;
        logic [N-1:0]      data;
    } entry_t;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    entry_t            fifo_head;
    entry_t            fifo_entries [FIFO_DEPTH];
    logic [1:0]        fifo_valid;
    logic              fifo_push;
    logic              fifo_pop;
    entry_t            ld_entry;

    logic              wr_en_q, wr_en_d;
    logic [N-1:0]      wr_data_q, wr_data_d;
    logic [R_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        pend_hit;

    assign ld_entry  = '{addr: bus.ldAddr, data: bus.ldData};
    assign fifo_push = bus.ldValid && !fifo_full;
    assign fifo_pop  = !bus.aluValid && !fifo_empty;

    wb_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .push_entry (ld_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (fifo_head),
        .entries    (fifo_entries),
        .valid      (fifo_valid)
    );

    // The ALU has no backpressure, so it always wins; an idle cycle keeps the last data/addr.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        if (bus.aluValid) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.aluData;
            wr_addr_d = bus.aluAddr;
        end else if (!fifo_empty) begin
            wr_en_d   = 1'b1;
            wr_data_d = fifo_head.data;
            wr_addr_d = fifo_head.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign bus.wrEnable = wr_en_q;
    assign bus.wrData   = wr_data_q;
    assign bus.wrAddr   = wr_addr_q;
    assign bus.ldReady  = !fifo_full;

    // Only buffered loads count as pending; the ALU write in flight is the caller's concern.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_pend
        assign pend_hit[gi] = fifo_valid[gi] && (fifo_entries[gi].addr == bus.qAddr);
    end
    assign bus.qPending = |pend_hit;

`ifdef WB_BYPASS_EN
    logic byp_hit;
    assign byp_hit      = wr_en_q && (wr_addr_q == bus.qAddr);
    assign bus.bypValid = byp_hit;
    assign bus.bypData  = byp_hit ? wr_data_q : '0;
`else
    assign bus.bypValid = 1'b0;
    assign bus.bypData  = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^fifo_count;

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed scoreboard bench for gpr_writeback: expected writes are queued in hand-computed order and
// a negedge monitor compares every committed write against the queue head.
`timescale 1ns/1ps
module tb_gpr_writeback;
    localparam int N      = 8;
    localparam int R_SIZE = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpr_writeback_if #(.N(N), .R_SIZE(R_SIZE)) bus ();

    gpr_writeback #(.N(N), .R_SIZE(R_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [R_SIZE-1:0] addr;
        logic [N-1:0]      data;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [R_SIZE-1:0] a, input logic [N-1:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic set_alu(input logic v, input logic [R_SIZE-1:0] a, input logic [N-1:0] d);
        bus.aluValid = v;
        bus.aluAddr  = a;
        bus.aluData  = d;
    endtask

    task automatic set_ld(input logic v, input logic [R_SIZE-1:0] a, input logic [N-1:0] d);
        bus.ldValid = v;
        bus.ldAddr  = a;
        bus.ldData  = d;
    endtask

    // Monitor: every committed write must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wrEnable === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                         bus.wrAddr, bus.wrData);
            end else begin
                e = exp_q.pop_front();
                if (bus.wrAddr !== e.addr || bus.wrData !== e.data) begin
                    bad++;
                    $display("FAIL write_order: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             bus.wrAddr, bus.wrData, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%02h", bus.wrAddr, bus.wrData);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        set_alu(1'b1, 3'd7, 8'hFF);
        set_ld(1'b0, 3'd0, 8'h00);
        bus.qAddr = 3'd0;

        // 1: reset held two cycles with ALU active
        tick();
        tick();
        chk("reset_wren", {31'd0, bus.wrEnable}, 32'd0);
        chk("reset_wrdata", {24'd0, bus.wrData}, 32'h00);
        chk("reset_wraddr", {29'd0, bus.wrAddr}, 32'd0);
        reset = 1'b0;
        set_alu(1'b0, 3'd0, 8'h00);
        tick();
        chk("reset_ldready", {31'd0, bus.ldReady}, 32'd1);
        chk("reset_idle_wren", {31'd0, bus.wrEnable}, 32'd0);

        // 2: single ALU write, latency 1, one cycle only
        expect_wr(3'd3, 8'h5A);
        set_alu(1'b1, 3'd3, 8'h5A);
        tick();
        chk("alu_wren", {31'd0, bus.wrEnable}, 32'd1);
        chk("alu_wraddr", {29'd0, bus.wrAddr}, 32'd3);
        set_alu(1'b0, 3'd0, 8'h00);
        tick();
        chk("alu_one_cycle", {31'd0, bus.wrEnable}, 32'd0);
        chk("idle_hold_data", {24'd0, bus.wrData}, 32'h5A);

        // 3: load held behind two ALU writes
        expect_wr(3'd4, 8'hA1);
        expect_wr(3'd4, 8'hA2);
        expect_wr(3'd2, 8'h11);
        bus.qAddr = 3'd2;
        set_ld(1'b1, 3'd2, 8'h11);
        tick();
        chk("pend_after_accept", {31'd0, bus.qPending}, 32'd1);
        set_ld(1'b0, 3'd0, 8'h00);
        set_alu(1'b1, 3'd4, 8'hA1);
        tick();
        chk("pend_alu1", {31'd0, bus.qPending}, 32'd1);
        set_alu(1'b1, 3'd4, 8'hA2);
        tick();
        chk("pend_alu2", {31'd0, bus.qPending}, 32'd1);
        set_alu(1'b0, 3'd0, 8'h00);
        tick();
        chk("pend_cleared", {31'd0, bus.qPending}, 32'd0);
        chk("load_wraddr", {29'd0, bus.wrAddr}, 32'd2);
        tick();

        // 4 + 5: three loads under ALU pressure, then push and pop together
        expect_wr(3'd0, 8'hB0);
        expect_wr(3'd0, 8'hB1);
        expect_wr(3'd0, 8'hB2);
        expect_wr(3'd1, 8'h31);
        expect_wr(3'd5, 8'h35);
        expect_wr(3'd6, 8'h36);
        set_alu(1'b1, 3'd0, 8'hB0);
        set_ld(1'b1, 3'd1, 8'h31);
        chk("ld1_ready", {31'd0, bus.ldReady}, 32'd1);
        tick();
        set_alu(1'b1, 3'd0, 8'hB1);
        set_ld(1'b1, 3'd5, 8'h35);
        chk("ld2_ready", {31'd0, bus.ldReady}, 32'd1);
        tick();
        chk("full_ldready", {31'd0, bus.ldReady}, 32'd0);
        bus.qAddr = 3'd5;
        set_alu(1'b1, 3'd0, 8'hB2);
        set_ld(1'b1, 3'd6, 8'h36);
        #1;
        chk("pend_second", {31'd0, bus.qPending}, 32'd1);
        tick();
        chk("full_ignored", {31'd0, bus.ldReady}, 32'd0);
        bus.qAddr = 3'd6;
        set_alu(1'b0, 3'd0, 8'h00);
        #1;
        chk("pend_not_taken", {31'd0, bus.qPending}, 32'd0);
        tick();
        chk("after_pop_ready", {31'd0, bus.ldReady}, 32'd1);
        tick();
        chk("pushpop_ready", {31'd0, bus.ldReady}, 32'd1);
        chk("pushpop_pend6", {31'd0, bus.qPending}, 32'd1);
        set_ld(1'b0, 3'd0, 8'h00);
        tick();
        chk("drained_pend", {31'd0, bus.qPending}, 32'd0);
        tick();

        // 6: bypass of the write being committed
        expect_wr(3'd7, 8'hC3);
        set_alu(1'b1, 3'd7, 8'hC3);
        tick();
        set_alu(1'b0, 3'd0, 8'h00);
        bus.qAddr = 3'd7;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_hit_valid", {31'd0, bus.bypValid}, 32'd1);
        chk("byp_hit_data", {24'd0, bus.bypData}, 32'hC3);
`else
        chk("byp_off_valid", {31'd0, bus.bypValid}, 32'd0);
        chk("byp_off_data", {24'd0, bus.bypData}, 32'h00);
`endif
        bus.qAddr = 3'd6;
        #1;
        chk("byp_miss_valid", {31'd0, bus.bypValid}, 32'd0);
        chk("byp_miss_data", {24'd0, bus.bypData}, 32'h00);
        tick();

        // Reset with the buffer full drops both loads
        expect_wr(3'd0, 8'hD0);
        expect_wr(3'd0, 8'hD1);
        set_alu(1'b1, 3'd0, 8'hD0);
        set_ld(1'b1, 3'd3, 8'h43);
        tick();
        set_alu(1'b1, 3'd0, 8'hD1);
        set_ld(1'b1, 3'd4, 8'h44);
        tick();
        bus.qAddr = 3'd4;
        set_ld(1'b0, 3'd0, 8'h00);
        set_alu(1'b1, 3'd1, 8'hD2);
        #1;
        chk("midrst_full", {31'd0, bus.ldReady}, 32'd0);
        chk("midrst_pend", {31'd0, bus.qPending}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_alu(1'b0, 3'd0, 8'h00);
        #1;
        chk("midrst_wren", {31'd0, bus.wrEnable}, 32'd0);
        chk("midrst_ready", {31'd0, bus.ldReady}, 32'd1);
        chk("midrst_pend_clr", {31'd0, bus.qPending}, 32'd0);
        tick();
        chk("midrst_no_write", {31'd0, bus.wrEnable}, 32'd0);
        tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
